// File: rtl/video_pkg.sv
// Shared types, sizing constants and the RGB565-to-grey conversion for the video
// capture and display paths.
package video_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_e;

    localparam int CELL_LOG2 = 2;
    localparam int GRID_LOG2 = 6;
    localparam int ADDR_W    = 12;
    localparam int GREY_W    = 9;

    // Unweighted sum scaled by 4: full white (31,63,31) maps to 500.
    function automatic logic [GREY_W-1:0] rgb565_to_grey(input logic [4:0] r,
                                                         input logic [5:0] g,
                                                         input logic [4:0] b);
        logic [6:0] s;
        s = 7'(r) + 7'(g) + 7'(b);
        return {s, 2'b00};
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Input registers, DE/VSYNC edge detection, pixel/line counters and capture-window
// flags for the video capture path.
module video_timing_counter #(
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int CELL_LOG2     = 2,
    parameter int GRID_LOG2     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vs_i,
    input  logic                 hs_i,
    input  logic                 de_i,
    input  logic [4:0]           r_i,
    input  logic [5:0]           g_i,
    input  logic [4:0]           b_i,
    output logic                 vs_edge_o,
    output logic                 pix_ok_o,
    output logic [CELL_LOG2-1:0] sub_o,
    output logic [GRID_LOG2-1:0] col_o,
    output logic [GRID_LOG2-1:0] row_o,
    output logic [8:0]           grey_o
);
    import video_pkg::*;

    localparam logic [15:0] X0    = 16'(START_X);
    localparam logic [15:0] Y0    = 16'(START_Y);
    localparam logic [15:0] WIN16 = 16'(1 << (CELL_LOG2 + GRID_LOG2));

    logic        vs_s1_q, vs_s2_q, hs_s1_q, de_s1_q, de_s2_q;
    logic [4:0]  r_s1_q, b_s1_q;
    logic [5:0]  g_s1_q;
    logic [15:0] px_q, px_d, ln_q, ln_d, px_cur, ln_cur;
    logic [16:0] dx, dy;
    logic        vs_act_s1, vs_act_s2, de_rise, de_fall, vs_edge;

    // hs is captured with the other inputs but plays no part in timing.
    logic unused_hs;
    assign unused_hs = hs_s1_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        vs_act_s1 = (VS_ACTIVE_LOW != 0) ? ~vs_s1_q : vs_s1_q;
        vs_act_s2 = (VS_ACTIVE_LOW != 0) ? ~vs_s2_q : vs_s2_q;
        de_rise   = de_s1_q & ~de_s2_q;
        de_fall   = ~de_s1_q & de_s2_q;
        vs_edge   = vs_act_s1 & ~vs_act_s2;
        // px_cur/ln_cur are the coordinates of the pixel currently held in S1.
        px_cur    = de_rise ? 16'd0 : px_q;
        ln_cur    = vs_edge ? 16'd0 : ln_q;
        px_d      = px_cur;
        ln_d      = ln_cur;
        if (de_s1_q && px_cur != 16'hFFFF) px_d = px_cur + 16'd1;
        if (de_fall && ln_cur != 16'hFFFF) ln_d = ln_cur + 16'd1;
        // Bit 16 is the borrow: set when the coordinate lies before the window start.
        dx        = {1'b0, px_cur} - {1'b0, X0};
        dy        = {1'b0, ln_cur} - {1'b0, Y0};
    end

    assign vs_edge_o = vs_edge;
    assign pix_ok_o  = de_s1_q && !dx[16] && (dx[15:0] < WIN16)
                                && !dy[16] && (dy[15:0] < WIN16)
                                && (dy[CELL_LOG2-1:0] == '0);
    assign sub_o     = dx[CELL_LOG2-1:0];
    assign col_o     = dx[CELL_LOG2 +: GRID_LOG2];
    assign row_o     = dy[CELL_LOG2 +: GRID_LOG2];
    assign grey_o    = rgb565_to_grey(r_s1_q, g_s1_q, b_s1_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            hs_s1_q <= 1'b0;
            de_s1_q <= 1'b0;
            de_s2_q <= 1'b0;
            r_s1_q  <= '0;
            g_s1_q  <= '0;
            b_s1_q  <= '0;
            px_q    <= '0;
            ln_q    <= '0;
        end else begin
            vs_s1_q <= vs_i;
            vs_s2_q <= vs_s1_q;
            hs_s1_q <= hs_i;
            de_s1_q <= de_i;
            de_s2_q <= de_s1_q;
            r_s1_q  <= r_i;
            g_s1_q  <= g_i;
            b_s1_q  <= b_i;
            px_q    <= px_d;
            ln_q    <= ln_d;
        end
    end

endmodule

// File: rtl/video_capture.sv
// Single-frame video capture: decimates a window of the incoming RGB565 stream into
// 64x64 grey samples for BSRAM. Define CAPTURE_AVG_EN for horizontal box averaging.
module video_capture #(
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int CELL_LOG2     = video_pkg::CELL_LOG2,
    parameter int GRID_LOG2     = video_pkg::GRID_LOG2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm_i,
    input  logic                         vs_i,
    input  logic                         hs_i,
    input  logic                         de_i,
    input  logic [4:0]                   r_i,
    input  logic [5:0]                   g_i,
    input  logic [4:0]                   b_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         short_o,
    output logic                         we_o,
    output logic [2*GRID_LOG2-1:0]       waddr_o,
    output logic [video_pkg::GREY_W-1:0] wdata_o
);
    import video_pkg::*;

    localparam int             AW        = 2 * GRID_LOG2;
    localparam logic [AW-1:0]  LAST_ADDR = '1;

    logic                 vs_edge, pix_ok, sample, last_wr;
    logic [CELL_LOG2-1:0] sub;
    logic [GRID_LOG2-1:0] col, row;
    logic [GREY_W-1:0]    grey, wr_data;

    state_e               state_q, state_d;
    logic                 busy_q, busy_d, done_q, done_d, short_q, short_d, we_q, we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [GREY_W-1:0]    wdata_q, wdata_d;

    video_timing_counter #(
        .START_X       (START_X),
        .START_Y       (START_Y),
        .VS_ACTIVE_LOW (VS_ACTIVE_LOW),
        .CELL_LOG2     (CELL_LOG2),
        .GRID_LOG2     (GRID_LOG2)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .vs_i      (vs_i),
        .hs_i      (hs_i),
        .de_i      (de_i),
        .r_i       (r_i),
        .g_i       (g_i),
        .b_i       (b_i),
        .vs_edge_o (vs_edge),
        .pix_ok_o  (pix_ok),
        .sub_o     (sub),
        .col_o     (col),
        .row_o     (row),
        .grey_o    (grey)
    );

`ifdef CAPTURE_AVG_EN
    localparam int SUM_W = GREY_W + CELL_LOG2;
    logic [SUM_W-1:0] sum_q, sum_d;

    // A cell is written on its last pixel; a cell cut short by DE falling never reaches it.
    always_comb begin
        sum_d = sum_q;
        if (pix_ok) sum_d = (sub == '0) ? SUM_W'(grey) : sum_q + SUM_W'(grey);
        sample  = pix_ok && (sub == '1);
        wr_data = sum_d[SUM_W-1 -: GREY_W];
    end
`else
    always_comb begin
        sample  = pix_ok && (sub == '0);
        wr_data = grey;
    end
`endif

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        short_d = short_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        // The final write takes priority over a VSYNC edge arriving in the same cycle.
        last_wr = we_q && (waddr_q == LAST_ADDR);
        case (state_q)
            IDLE: begin
                if (arm_i) begin
                    busy_d  = 1'b1;
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_edge) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (last_wr || vs_edge) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    short_d = !last_wr;
                end else if (sample) begin
                    we_d    = 1'b1;
                    waddr_d = {row, col};
                    wdata_d = wr_data;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef CAPTURE_AVG_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            short_q <= short_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef CAPTURE_AVG_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign short_o = short_q;
    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_video_capture.sv
// Self-checking bench for video_capture: reset/arm table, frame-level reference model
// with a write scoreboard, and hand sequences for the multi-cycle corner cases.
module tb_video_capture;

    logic        clk = 1'b0;
    logic        rst, arm_i, vs_i, hs_i, de_i;
    logic [4:0]  r_i, b_i;
    logic [5:0]  g_i;
    logic        busy_o, done_o, short_o, we_o;
    logic [11:0] waddr_o;
    logic [8:0]  wdata_o;

    video_capture dut (
        .clk     (clk),
        .rst     (rst),
        .arm_i   (arm_i),
        .vs_i    (vs_i),
        .hs_i    (hs_i),
        .de_i    (de_i),
        .r_i     (r_i),
        .g_i     (g_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .short_o (short_o),
        .we_o    (we_o),
        .waddr_o (waddr_o),
        .wdata_o (wdata_o)
    );

    always #5 clk = ~clk;

`ifdef CAPTURE_AVG_EN
    localparam int LAST_W = 256;
`else
    localparam int LAST_W = 253;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model state: frame-level capture status and expected writes.
    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t exp_q[$];
    int  cyc = 0;
    int  wr_cnt = 0, done_cnt = 0, exp_done = 0, stop_after = 0;
    int  seen[4096];
    bit  exp_short = 1'b0;
    bit  cap_armed = 1'b0, cap_active = 1'b0, cap_fin = 1'b0;
    int  ln_m = 0, acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_o) begin
            wr_cnt++;
            seen[waddr_o] = wdata_o;
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(waddr_o), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("waddr", int'(waddr_o), e.addr);
                check("wdata", int'(wdata_o), e.data);
                check("wlatency", cyc, e.cyc);
            end
        end
        if (done_o) begin
            done_cnt++;
            check("busy_with_done", int'(busy_o), 0);
            check("short_with_done", int'(short_o), int'(exp_short));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected write for one active pixel at (px, ln_m), from the capture rules.
    task automatic model_pix(input int px, input int gr);
        int addr;
        if (!cap_active || cap_fin || px >= 256 || ln_m >= 256 || (ln_m % 4) != 0) return;
`ifdef CAPTURE_AVG_EN
        acc = ((px % 4) == 0) ? gr : acc + gr;
        if ((px % 4) != 3) return;
        gr = acc / 4;
`else
        if ((px % 4) != 0) return;
`endif
        addr = (ln_m / 4) * 64 + px / 4;
        exp_q.push_back('{addr, gr, cyc + 2});
        if (addr == 4095) begin
            cap_fin   = 1'b1;
            exp_short = 1'b0;
            exp_done++;
        end
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("busy_after_arm", int'(busy_o), 1);
        if (!cap_active && !cap_armed) cap_armed = 1'b1;
    endtask

    task automatic vsync(input int len);
        de_i = 1'b0;
        vs_i = 1'b0;
        if (cap_active) begin
            if (!cap_fin) begin
                exp_short = 1'b1;
                exp_done++;
            end
            cap_active = 1'b0;
        end else if (cap_armed) begin
            cap_armed  = 1'b0;
            cap_active = 1'b1;
            cap_fin    = 1'b0;
        end
        ln_m = 0;
        repeat (len) tick();
        vs_i = 1'b1;
        repeat (2) tick();
    endtask

    // mode 0: black with one white pixel at (4,8); 1: random; 2: red ramp r=px.
    task automatic line(input int w, input int hb, input int mode);
        logic [15:0] rgb;
        for (int px = 0; px < w; px++) begin
            case (mode)
                0:       rgb = (px == 4 && ln_m == 8) ? 16'hFFFF : 16'h0000;
                1:       rgb = 16'($urandom);
                default: rgb = {5'(px), 11'd0};
            endcase
            if (mode == 1 && $urandom_range(0, 7) == 0) hs_i = ~hs_i;
            de_i = 1'b1;
            r_i  = rgb[15:11];
            g_i  = rgb[10:5];
            b_i  = rgb[4:0];
            model_pix(px, 4 * (int'(rgb[15:11]) + int'(rgb[10:5]) + int'(rgb[4:0])));
            tick();
            if (stop_after > 0 && wr_cnt >= stop_after) return;
        end
        de_i = 1'b0;
        r_i  = '0;
        g_i  = '0;
        b_i  = '0;
        if (w > 0) ln_m++;
        repeat (hb) begin
            hs_i = ~hs_i;
            tick();
        end
    endtask

    typedef struct { bit rst; bit arm; bit busy; } vec_t;
    vec_t vecs[9];

    initial begin
        int w0, d0, nl;
        rst = 1'b1; arm_i = 1'b1; vs_i = 1'b1; hs_i = 1'b0; de_i = 1'b0;
        r_i = '0; g_i = '0; b_i = '0;
        for (int i = 0; i < 4096; i++) seen[i] = -1;

        // Reset holds everything low even with arm_i high; arm is accepted after release.
        vecs = '{'{1, 1, 0}, '{1, 1, 0}, '{1, 1, 0}, '{0, 0, 0}, '{0, 1, 1},
                 '{0, 0, 1}, '{0, 1, 1}, '{1, 0, 0}, '{0, 0, 0}};
        for (int i = 0; i < 9; i++) begin
            rst   = vecs[i].rst;
            arm_i = vecs[i].arm;
            tick();
            check($sformatf("vec%0d_busy", i), int'(busy_o), int'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), int'(done_o), 0);
            check($sformatf("vec%0d_we", i), int'(we_o), 0);
            check($sformatf("vec%0d_short", i), int'(short_o), 0);
            check($sformatf("vec%0d_waddr", i), int'(waddr_o), 0);
            check($sformatf("vec%0d_wdata", i), int'(wdata_o), 0);
        end
        arm_i = 1'b0;

        // Full frame; the closing VSYNC edge lands in the same cycle as the last write.
        w0 = wr_cnt; d0 = done_cnt;
        pulse_arm();
        vsync(2);
        for (int l = 0; l < 252; l++) begin
            line(256, 1, 0);
            if (l == 100) pulse_arm();
        end
        line(LAST_W, 0, 0);
        vsync(2);
        repeat (8) tick();
        check("full_writes", wr_cnt - w0, 4096);
        check("full_done_pulses", done_cnt - d0, 1);
        check("full_done_model", done_cnt, exp_done);
        check("full_queue_empty", exp_q.size(), 0);
        check("full_busy_after", int'(busy_o), 0);
`ifdef CAPTURE_AVG_EN
        check("full_addr081", seen[12'h081], 125);
`else
        check("full_addr081", seen[12'h081], 500);
`endif

        // Random short frames with ragged and empty lines.
        for (int f = 0; f < 2; f++) begin
            pulse_arm();
            vsync(2);
            nl = $urandom_range(6, 14);
            for (int l = 0; l < nl; l++) line($urandom_range(0, 280), $urandom_range(1, 3), 1);
            vsync(2);
            repeat (6) tick();
            check($sformatf("rand%0d_done", f), done_cnt, exp_done);
            check($sformatf("rand%0d_queue", f), exp_q.size(), 0);
        end

        // DE never asserted: capture ends short on the next VSYNC with no writes.
        w0 = wr_cnt;
        pulse_arm();
        vsync(2);
        repeat (5) line(0, 10, 1);
        vsync(2);
        repeat (6) tick();
        check("nodata_writes", wr_cnt - w0, 0);
        check("nodata_done", done_cnt, exp_done);

        // Two-line sequence: complete cell on row 0, DE falls at px=2 on row 1.
        w0 = wr_cnt;
        seen[0] = -1;
        pulse_arm();
        vsync(2);
        line(4, 2, 2);
        repeat (3) line(4, 2, 2);
        line(2, 2, 2);
        vsync(2);
        repeat (6) tick();
`ifdef CAPTURE_AVG_EN
        check("avg_writes", wr_cnt - w0, 1);
        check("avg_cell0", seen[0], 6);
`else
        check("tl_writes", wr_cnt - w0, 2);
        check("tl_cell0", seen[0], 0);
`endif
        check("ramp_queue", exp_q.size(), 0);

        // Reset after 100 writes: we_o drops next clk, no done, FSM back in IDLE.
        pulse_arm();
        vsync(2);
        stop_after = wr_cnt + 100;
        for (int l = 0; l < 20; l++) begin
            line(256, 2, 1);
            if (wr_cnt >= stop_after) break;
        end
        stop_after = 0;
        de_i = 1'b0;
        rst  = 1'b1;
        tick();
        check("rst_we", int'(we_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst = 1'b0;
        exp_q.delete();
        cap_active = 1'b0;
        cap_armed  = 1'b0;
        d0 = done_cnt;
        repeat (10) tick();
        check("rst_no_done", done_cnt - d0, 0);
        w0 = wr_cnt;
        vsync(2);
        line(256, 2, 1);
        vsync(2);
        repeat (6) tick();
        check("idle_no_writes", wr_cnt - w0, 0);
        check("idle_busy", int'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
